key_exp_inv: RTL and testbench



---
 rtl/key_exp_inv_pkg.sv | 42 ++++
 rtl/key_exp_inv_if.sv | 27 ++
 rtl/key_exp_inv.sv | 177 +++++++++++++++++
 tb/tb_key_exp_inv.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_exp_inv_pkg.sv
// Shared definitions for the inverse AES-128 single-round key expansion:
// FSM state encoding, the byte type, the Rcon table and index helpers.
package key_exp_inv_pkg;

  // One AES state byte.
  typedef logic [7:0] aes_byte_t;

  // Inverse key expansion sequencer states.
  typedef enum logic [2:0] {
    KI_IDLE,
    KI_LOAD,
    KI_XOR,
    KI_SUB,
    KI_COL0,
    KI_OUT
  } ki_state_e;

  localparam int unsigned KEY_BYTES  = 16;
  localparam int unsigned NUM_ROUNDS = 10;

  // Rcon of rounds 1..10. Decryption walks this table from round 10 down to 1.
  localparam aes_byte_t RCON_TBL [1:NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rcon for a round number; rounds outside 1..10 give 00.
  function automatic aes_byte_t rcon_of_round(input int unsigned round);
    aes_byte_t rc;
    rc = 8'h00;
    for (int unsigned r = 1; r <= NUM_ROUNDS; r++) begin
      if (round == r) rc = RCON_TBL[r];
    end
    return rc;
  endfunction

  // Stream position of a key byte: bytes go out row-major, k = 4*row + col.
  function automatic logic [3:0] byte_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/key_exp_inv_if.sv
// Byte-serial key stream and S-box lookup port of the inverse key expansion.
// slave is the key expansion block itself; master is whatever feeds it
// (key source plus the shared forward S-box).
interface key_exp_inv_if;
  import key_exp_inv_pkg::*;

  aes_byte_t din;          // round-key-N byte
  logic      enable_din;   // din valid this cycle
  aes_byte_t rcon;         // Rcon of round N, taken with the first byte
  aes_byte_t sbox_in;      // S-box result, one cycle after the request
  aes_byte_t addr_out;     // S-box address
  logic      enable_sbox;  // S-box lookup request
  aes_byte_t dout;         // round-key-(N-1) byte
  logic      enable_out;   // dout valid
  logic      busy;         // key in flight

  modport slave (
    input  din, enable_din, rcon, sbox_in,
    output addr_out, enable_sbox, dout, enable_out, busy
  );

  modport master (
    output din, enable_din, rcon, sbox_in,
    input  addr_out, enable_sbox, dout, enable_out, busy
  );

endinterface

// File: rtl/key_exp_inv.sv
// Inverse single-round AES-128 key expansion.
// Takes round key N byte-serially (row-major), derives round key N-1:
//   P3 = W3^W2, P2 = W2^W1, P1 = W1^W0,
//   P0 = W0 ^ SubWord(RotWord(P3)) ^ {rcon,00,00,00}
// and streams it out row-major. SubWord goes through the external shared
// forward S-box, one registered request per byte.
module key_exp_inv
  import key_exp_inv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  key_exp_inv_if.slave bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ki_state_e  state_q;
  logic [4:0] cnt_q;                  // byte index in LOAD/OUT, step index in XOR/SUB
  aes_byte_t  rcon_q;

  aes_byte_t  in_q  [KEY_BYTES];      // round key N
  aes_byte_t  out_q [KEY_BYTES];      // round key N-1
  aes_byte_t  sub_q [4];              // SubWord(RotWord(P3)), indexed by P0 row

  // Registered outputs
  aes_byte_t  addr_q;
  logic       enable_sbox_q;
  aes_byte_t  dout_q;
  logic       enable_out_q;
  logic       busy_q;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [1:0] xor_col_d;              // column produced this XOR step (3, 2, 1)
  logic [1:0] sub_row_d;              // P3 row of the next S-box request
  aes_byte_t  xor_d [4];              // Pc = Wc ^ Wc-1, one byte per row
  aes_byte_t  p0_d  [4];              // P0 = W0 ^ SubWord(RotWord(P3)) ^ Rcon

  // Column XOR for the current step and the final P0 column.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missed
    // assignment infers a latch.
    xor_col_d = 2'd3 - cnt_q[1:0];
    // Requests after the first one cover rows 2, 3, 0 (RotWord order).
    sub_row_d = cnt_q[1:0] + 2'd2;
    for (int r = 0; r < 4; r++) begin
      xor_d[r] = in_q[byte_idx(2'(r), xor_col_d)]
               ^ in_q[byte_idx(2'(r), xor_col_d - 2'd1)];
      // Rcon only touches the top byte of the word (row 0).
      p0_d[r]  = in_q[byte_idx(2'(r), 2'd0)] ^ sub_q[r]
               ^ ((r == 0) ? rcon_q : 8'h00);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: load, three column XORs, four S-box lookups, P0, stream out.
  // ---------------------------------------------------------------------------
  // FSM, counters, key storage and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the byte stores are left out of reset on purpose: every byte is
      // written before it is read, and resettable storage costs flops.
      // NOTE: sequential state uses non-blocking assignment only, so every
      // register here sees the pre-edge value of every other register.
      state_q       <= KI_IDLE;
      cnt_q         <= '0;
      rcon_q        <= '0;
      addr_q        <= '0;
      enable_sbox_q <= 1'b0;
      dout_q        <= '0;
      enable_out_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        // First byte also latches Rcon; later rcon values are ignored.
        KI_IDLE: begin
          if (bus.enable_din) begin
            in_q[0] <= bus.din;
            rcon_q  <= bus.rcon;
            busy_q  <= 1'b1;
            cnt_q   <= 5'd1;
            state_q <= KI_LOAD;
          end
        end

        // Bytes 1..15, one per valid cycle; gaps simply wait.
        KI_LOAD: begin
          if (bus.enable_din) begin
            in_q[cnt_q[3:0]] <= bus.din;
            if (cnt_q == 5'd15) begin
              cnt_q   <= '0;
              state_q <= KI_XOR;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        // P3, P2, P1 in that order. P3 is ready after the first step, so the
        // first S-box request (P3 row 1) is launched on the last step.
        KI_XOR: begin
          for (int r = 0; r < 4; r++) begin
            out_q[byte_idx(2'(r), xor_col_d)] <= xor_d[r];
          end
          if (cnt_q == 5'd2) begin
            addr_q        <= out_q[byte_idx(2'd1, 2'd3)];
            enable_sbox_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= KI_SUB;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end

        // Steps 0..2 issue requests for rows 2, 3, 0; steps 1..4 capture the
        // result of the previous request. addr_q then holds its last value.
        KI_SUB: begin
          if (cnt_q != 5'd0) begin
            sub_q[2'(cnt_q - 5'd1)] <= bus.sbox_in;
          end
          if (cnt_q < 5'd3) begin
            addr_q <= out_q[byte_idx(sub_row_d, 2'd3)];
          end else begin
            enable_sbox_q <= 1'b0;
          end
          if (cnt_q == 5'd4) begin
            cnt_q   <= '0;
            state_q <= KI_COL0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end

        // P0 column; byte 0 goes straight to the output register.
        KI_COL0: begin
          for (int r = 0; r < 4; r++) begin
            out_q[byte_idx(2'(r), 2'd0)] <= p0_d[r];
          end
          dout_q       <= p0_d[0];
          enable_out_q <= 1'b1;
          cnt_q        <= 5'd1;
          state_q      <= KI_OUT;
        end

        // cnt_q is the next byte to present; after byte 15 has been shown for
        // its cycle, return to IDLE so a new key can start immediately.
        KI_OUT: begin
          if (cnt_q == 5'd16) begin
            enable_out_q <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            state_q      <= KI_IDLE;
          end else begin
            dout_q <= out_q[cnt_q[3:0]];
            cnt_q  <= cnt_q + 5'd1;
          end
        end

        default: begin
          state_q <= KI_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign bus.addr_out    = addr_q;
  assign bus.enable_sbox = enable_sbox_q;
  assign bus.dout        = dout_q;
  assign bus.enable_out  = enable_out_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_key_exp_inv.sv
// Self-checking bench for key_exp_inv: FIPS-197 vectors, gapped input,
// garbage while busy, reset mid-lookup, back-to-back keys and random keys,
// all compared against a word-level model of the inverse key schedule.
module tb_key_exp_inv;
  import key_exp_inv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  key_exp_inv_if kif ();

  key_exp_inv u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t15 = 0;

  logic [7:0] sbox_tbl [256];

  // Observed traffic, appended only by the monitor.
  logic [7:0] got_out  [$];
  int         oe_cyc   [$];
  logic [7:0] got_addr [$];

  localparam logic [127:0] V1_IN  = 128'ha088232afa54a36cfe2c397617b13905;
  localparam logic [127:0] V1_OUT = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] V2_IN  = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;
  localparam logic [127:0] V2_OUT = 128'hac19285777fad15c66dc2900f321416e;

  always @(posedge clk) cyc <= cyc + 1;

  // Forward S-box ROM: answer one cycle after a request, noise otherwise.
  always @(posedge clk)
    kif.sbox_in <= kif.enable_sbox ? sbox_tbl[kif.addr_out] : 8'($urandom);

  always @(negedge clk) begin
    if (kif.enable_out) begin
      got_out.push_back(kif.dout);
      oe_cyc.push_back(cyc);
    end
    if (kif.enable_sbox) got_addr.push_back(kif.addr_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model -----------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] kb(input logic [127:0] key, input int k);
    return key[127 - 8*k -: 8];
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] key, input int c);
    return {kb(key, c), kb(key, c + 4), kb(key, c + 8), kb(key, c + 12)};
  endfunction

  function automatic logic [127:0] key_of(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0]  w [4];
    logic [127:0] r;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*row + c) -: 8] = w[c][31 - 8*row -: 8];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
  endfunction

  // Undo one forward key-schedule step; also returns the S-box address word.
  task automatic ref_model(input logic [127:0] key, input logic [7:0] rc,
                           output logic [127:0] prev, output logic [31:0] addrs);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rot;
    w0 = word_of(key, 0); w1 = word_of(key, 1);
    w2 = word_of(key, 2); w3 = word_of(key, 3);
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    rot = {p3[23:0], p3[31:24]};
    p0 = w0 ^ sub_word(rot) ^ {rc, 24'h0};
    prev  = key_of(p0, p1, p2, p3);
    addrs = rot;
  endtask

  // ---- stimulus --------------------------------------------------------------
  // Called #1 after a rising edge with the DUT idle.
  task automatic drive_key(input logic [127:0] key, input logic [7:0] rc, input bit gapped);
    for (int k = 0; k < 16; k++) begin
      if (gapped && k != 0) begin
        kif.enable_din = 1'b0;
        kif.din        = 8'($urandom);
        kif.rcon       = 8'($urandom);
        @(posedge clk); #1;
      end
      kif.din        = kb(key, k);
      kif.enable_din = 1'b1;
      kif.rcon       = (k == 0) ? rc : 8'($urandom);
      if (k == 15) t15 = cyc;
      @(posedge clk); #1;
    end
    kif.enable_din = 1'b0;
  endtask

  // Streams one key, waits for busy to drop, checks output, latency and lookups.
  task automatic run_key(input string tag, input logic [127:0] key, input logic [7:0] rc,
                         input bit gapped, input bit garbage, input logic [127:0] exp_key);
    logic [127:0] m_key;
    logic [31:0]  m_addr;
    int ob, ab, waited, n_o, n_a;
    ref_model(key, rc, m_key, m_addr);
    ob = got_out.size();
    ab = got_addr.size();
    drive_key(key, rc, gapped);
    waited = 0;
    while (kif.busy && waited < 80) begin
      kif.enable_din = garbage;
      kif.din        = 8'($urandom);
      kif.rcon       = 8'($urandom);
      @(posedge clk); #1;
      waited++;
    end
    kif.enable_din = 1'b0;
    check({tag, ".done"}, 32'(waited < 80), 32'd1);
    n_o = got_out.size() - ob;
    n_a = got_addr.size() - ab;
    check({tag, ".beats"}, 32'(n_o), 32'd16);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s.b%0d", tag, k), (k < n_o) ? 32'(got_out[ob + k]) : 32'hxx,
            32'(kb(exp_key, k)));
    if (n_o > 0) begin
      check({tag, ".latency"}, 32'(oe_cyc[ob] - t15), 32'd10);
      check({tag, ".contig"}, 32'(oe_cyc[ob + n_o - 1] - oe_cyc[ob]), 32'd15);
    end
    check({tag, ".lookups"}, 32'(n_a), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.addr%0d", tag, i), (i < n_a) ? 32'(got_addr[ab + i]) : 32'hxx,
            32'(m_addr[31 - 8*i -: 8]));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] rk, mk;
    logic [31:0]  ma;
    logic [7:0]   rc;
    logic [7:0]   inv;

    kif.din = '0; kif.enable_din = 1'b0; kif.rcon = '0;

    // Forward S-box from its definition: GF(2^8) inverse then affine map.
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      if (i != 0)
        for (int j = 1; j < 256; j++)
          if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      sbox_tbl[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.dout", 32'(kif.dout), 32'h0);
    check("rst.addr", 32'(kif.addr_out), 32'h0);
    check("rst.sbox_en", 32'(kif.enable_sbox), 32'h0);
    check("rst.out_en", 32'(kif.enable_out), 32'h0);
    check("rst.busy", 32'(kif.busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    run_key("v1", V1_IN, 8'h01, 1'b0, 1'b0, V1_OUT);
    idle(3);
    run_key("v2", V2_IN, rcon_of_round(10), 1'b0, 1'b0, V2_OUT);
    idle(2);
    run_key("v1_gap", V1_IN, 8'h01, 1'b1, 1'b0, V1_OUT);
    idle(2);
    run_key("v1_junk", V1_IN, 8'h01, 1'b0, 1'b1, V1_OUT);
    idle(2);

    // Reset in the middle of the S-box phase
    drive_key(V1_IN, 8'h01, 1'b0);
    idle(5);
    check("midrst.in_sub", 32'(kif.enable_sbox), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.dout", 32'(kif.dout), 32'h0);
    check("midrst.addr", 32'(kif.addr_out), 32'h0);
    check("midrst.sbox_en", 32'(kif.enable_sbox), 32'h0);
    check("midrst.out_en", 32'(kif.enable_out), 32'h0);
    check("midrst.busy", 32'(kif.busy), 32'h0);
    @(posedge clk); #1;
    run_key("v1_after_rst", V1_IN, 8'h01, 1'b0, 1'b0, V1_OUT);
    idle(1);

    // Back-to-back: second key starts in the cycle right after the last beat
    run_key("b2b_a", V1_IN, 8'h01, 1'b0, 1'b0, V1_OUT);
    run_key("b2b_b", V2_IN, 8'h36, 1'b0, 1'b0, V2_OUT);
    idle(2);

    // Random keys against the model
    for (int n = 0; n < 8; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rc = rcon_of_round($urandom_range(1, 10));
      ref_model(rk, rc, mk, ma);
      run_key($sformatf("rnd%0d", n), rk, rc, 1'($urandom), 1'($urandom), mk);
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
